fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the VeriRisc-style CPU, directly upstream of sequence_controller.
- Holds the program counter (PC) and the instruction register (IR), and drives the memory address mux.
- Feeds opcode to the controller and consumes the controller's load_ir, inc_pc, load_pc and halt strobes.
- Also keeps a sticky halted flag and a retired-instruction counter for debug.

Parameters:
- AWIDTH, 5, address width; PC and IR operand field width.
- DWIDTH, 8, instruction/memory data width; opcode is IR[DWIDTH-1:DWIDTH-3].
- CWIDTH, 16, width of instruction counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_  input  1  synchronous reset, active-high (rst_=1 resets on the clock edge).
- fetch  input  1  1 = fetch phase (address from PC); 0 = execute phase (address from IR operand).
- load_ir  input  1  capture mem_data into IR.
- inc_pc  input  1  PC increment.
- load_pc  input  1  PC <= IR operand (jump/skip target).
- halt  input  1  halt strobe from controller.
- mem_data  input  DWIDTH  instruction/data read from memory.
- addr  output  AWIDTH  memory address.
- pc  output  AWIDTH  current PC.
- opcode  output  3  IR[DWIDTH-1:DWIDTH-3], to controller.
- ir_addr  output  AWIDTH  IR[AWIDTH-1:0].
- halted  output  1  sticky halt status.
- instr_count  output  CWIDTH  number of load_ir captures.

Behaviour:
- Reset (rst_=1 at posedge): pc=0, IR=0 (so opcode=3'b000 and ir_addr=0), halted=0, instr_count=0.
  - Reset takes priority over every other input, including mid-instruction and while halted.
- addr is combinational: fetch ? pc : ir_addr. There is no register stage on addr.
- PC update priority per edge, when not halted:
  - load_pc: pc <= ir_addr, using IR value before this edge.
  - else inc_pc: pc <= pc+1 modulo 2^AWIDTH; 31 wraps to 0.
  - else: hold.
  - load_pc and inc_pc together: load_pc wins.
- IR update:
  - load_ir=1 and not halted: IR <= mem_data. opcode and ir_addr reflect the new value one cycle later (registered).
  - load_ir and load_pc in the same cycle: load_pc uses the old IR.
- instr_count:
  - Increments by 1 on each accepted load_ir.
  - Saturates at 2^CWIDTH-1 and never wraps.
- Halt:
  - halt=1 at an edge sets halted=1.
  - Updates requested in that same cycle (load_ir, inc_pc, load_pc) are still applied.
  - From the next edge onward, load_ir, inc_pc and load_pc are ignored: pc, IR and instr_count freeze.
  - halted clears only on reset. addr continues to follow fetch.
- X-safety: all registers have defined reset values; no latches.

Optional Feature:
- Macro: FETCH_BREAKPOINT_EN.
- When defined, the block adds:
  - Input bp_valid (1).
  - Input bp_addr (AWIDTH).
  - Output bp_hit (1).
- Breakpoint trigger: an accepted load_ir with bp_valid=1 and pc==bp_addr at that edge.
  - IR still captures mem_data and instr_count still increments.
  - halted is set at the same edge.
  - bp_hit is registered high for exactly one cycle after that edge.
  - bp_hit resets to 0.
- When not defined:
  - The three ports are absent.
  - There is no breakpoint logic.
  - Behaviour is identical to the base spec.

Test Plan:
1. Reset: drive random inputs with rst_=1 for 2 cycles -> pc=0, opcode=000, ir_addr=0, halted=0, instr_count=0. Then rst_=0, fetch=1 -> addr=0.
2. Fetch/increment: mem_data=8'b010_00111, load_ir pulse, then inc_pc pulse ->
   - opcode=010, ir_addr=7, pc=1, instr_count=1.
   - fetch=0 -> addr=7.
   - fetch=1 -> addr=1.
3. Wrap and priority:
   - From pc=31, inc_pc -> pc=0.
   - With IR=8'b111_10101 (JMP 21), assert load_pc and inc_pc together -> pc=21.
4. Halt freeze:
   - With pc=4, assert halt and inc_pc in one cycle -> pc=5, halted=1.
   - Then 10 cycles of inc_pc/load_ir/load_pc -> pc=5, IR and instr_count unchanged.
   - rst_=1 -> all cleared.
5. Counter saturation: with CWIDTH=4, 20 load_ir pulses -> instr_count=15, held.
6. With FETCH_BREAKPOINT_EN:
   - bp_valid=1, bp_addr=3; run inc_pc/load_ir until a load_ir occurs at pc=3.
   - Expect: bp_hit=1 for one cycle, halted=1, IR=mem_data captured.
   - A load_ir at pc=3 with bp_valid=0 gives no hit.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IR, memory address mux, sticky halt and retired-instruction counter.
// Optional breakpoint support is compiled in when FETCH_BREAKPOINT_EN is defined.
module fetch_unit #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              fetch,
  input  logic              load_ir,
  input  logic              inc_pc,
  input  logic              load_pc,
  input  logic              halt,
  input  logic [DWIDTH-1:0] mem_data,
`ifdef FETCH_BREAKPOINT_EN
  input  logic              bp_valid,
  input  logic [AWIDTH-1:0] bp_addr,
  output logic              bp_hit,
`endif
  output logic [AWIDTH-1:0] addr,
  output logic [AWIDTH-1:0] pc,
  output logic [2:0]        opcode,
  output logic [AWIDTH-1:0] ir_addr,
  output logic              halted,
  output logic [CWIDTH-1:0] instr_count
);

  localparam logic [AWIDTH-1:0] PC_ONE    = AWIDTH'(1);
  localparam logic [CWIDTH-1:0] CNT_ONE   = CWIDTH'(1);
  localparam logic [CWIDTH-1:0] CNT_MAX   = {CWIDTH{1'b1}};

  logic [DWIDTH-1:0] ir;
  logic              accept_ir;

  assign opcode    = ir[DWIDTH-1:DWIDTH-3];
  assign ir_addr   = ir[AWIDTH-1:0];
  assign addr      = fetch ? pc : ir_addr;
  assign accept_ir = load_ir && !halted;

  // Updates requested in the halting cycle still land; halted gates only later edges.
  always_ff @(posedge clk) begin
    if (rst_) begin
      pc          <= '0;
      ir          <= '0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      if (halt) begin
        halted <= 1'b1;
      end
      if (!halted) begin
        if (load_pc) begin
          pc <= ir_addr;
        end else if (inc_pc) begin
          pc <= pc + PC_ONE;
        end
      end
      if (accept_ir) begin
        ir <= mem_data;
        if (instr_count != CNT_MAX) begin
          instr_count <= instr_count + CNT_ONE;
        end
      end
`ifdef FETCH_BREAKPOINT_EN
      if (accept_ir && bp_valid && (pc == bp_addr)) begin
        halted <= 1'b1;
      end
`endif
    end
  end

`ifdef FETCH_BREAKPOINT_EN
  // One-cycle pulse following the edge that captured the breakpointed instruction.
  always_ff @(posedge clk) begin
    if (rst_) begin
      bp_hit <= 1'b0;
    end else begin
      bp_hit <= accept_ir && bp_valid && (pc == bp_addr);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table plus hand-written halt, saturation
// and (with FETCH_BREAKPOINT_EN) breakpoint sequences.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_, fetch, load_ir, inc_pc, load_pc, halt;
  logic [7:0] mem_data;

  logic [4:0]  addr, pc, ir_addr;
  logic [2:0]  opcode;
  logic        halted;
  logic [15:0] instr_count;

  logic [4:0]  addr_s, pc_s, ir_addr_s;
  logic [2:0]  opcode_s;
  logic        halted_s;
  logic [3:0]  instr_count_s;

`ifdef FETCH_BREAKPOINT_EN
  logic       bp_valid;
  logic [4:0] bp_addr;
  logic       bp_hit, bp_hit_s;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fetch_unit #(.AWIDTH(5), .DWIDTH(8), .CWIDTH(16)) dut (
    .clk(clk), .rst_(rst_), .fetch(fetch), .load_ir(load_ir), .inc_pc(inc_pc),
    .load_pc(load_pc), .halt(halt), .mem_data(mem_data),
`ifdef FETCH_BREAKPOINT_EN
    .bp_valid(bp_valid), .bp_addr(bp_addr), .bp_hit(bp_hit),
`endif
    .addr(addr), .pc(pc), .opcode(opcode), .ir_addr(ir_addr),
    .halted(halted), .instr_count(instr_count)
  );

  // Narrow-counter instance shares all inputs; only used to observe saturation.
  fetch_unit #(.AWIDTH(5), .DWIDTH(8), .CWIDTH(4)) dut_sat (
    .clk(clk), .rst_(rst_), .fetch(fetch), .load_ir(load_ir), .inc_pc(inc_pc),
    .load_pc(load_pc), .halt(halt), .mem_data(mem_data),
`ifdef FETCH_BREAKPOINT_EN
    .bp_valid(bp_valid), .bp_addr(bp_addr), .bp_hit(bp_hit_s),
`endif
    .addr(addr_s), .pc(pc_s), .opcode(opcode_s), .ir_addr(ir_addr_s),
    .halted(halted_s), .instr_count(instr_count_s)
  );

  typedef struct {
    logic        rst;
    logic        fch;
    logic        lir;
    logic        inc;
    logic        lpc;
    logic        hlt;
    logic [7:0]  mem;
    logic [4:0]  e_pc;
    logic [2:0]  e_op;
    logic [4:0]  e_ira;
    logic        e_hlt;
    logic [15:0] e_cnt;
    logic [4:0]  e_addr;
  } vec_t;

  vec_t vecs [17];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_     = v.rst;
    fetch    = v.fch;
    load_ir  = v.lir;
    inc_pc   = v.inc;
    load_pc  = v.lpc;
    halt     = v.hlt;
    mem_data = v.mem;
    tick();
  endtask

  task automatic idleInputs();
    rst_ = 1'b0; fetch = 1'b1; load_ir = 1'b0; inc_pc = 1'b0;
    load_pc = 1'b0; halt = 1'b0; mem_data = 8'h00;
  endtask

  initial begin
    rst_ = 1'b1; fetch = 1'b1; load_ir = 1'b0; inc_pc = 1'b0;
    load_pc = 1'b0; halt = 1'b0; mem_data = 8'h00;
`ifdef FETCH_BREAKPOINT_EN
    bp_valid = 1'b0;
    bp_addr  = 5'd0;
`endif

    //           rst   fch   lir   inc   lpc   hlt   mem      pc     op     ira    hlt   cnt     addr
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 5'd0,  3'd0, 5'd0,  1'b0, 16'd0, 5'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 5'd0,  3'd0, 5'd0,  1'b0, 16'd0, 5'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0,  3'd0, 5'd0,  1'b0, 16'd0, 5'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h47, 5'd0,  3'd2, 5'd7,  1'b0, 16'd1, 5'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd1,  3'd2, 5'd7,  1'b0, 16'd1, 5'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1,  3'd2, 5'd7,  1'b0, 16'd1, 5'd7};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1,  3'd2, 5'd7,  1'b0, 16'd1, 5'd1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1F, 5'd1,  3'd0, 5'd31, 1'b0, 16'd2, 5'd1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd31, 3'd0, 5'd31, 1'b0, 16'd2, 5'd31};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0,  3'd0, 5'd31, 1'b0, 16'd2, 5'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF5, 5'd0,  3'd7, 5'd21, 1'b0, 16'd3, 5'd0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 5'd21, 3'd7, 5'd21, 1'b0, 16'd3, 5'd21};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h24, 5'd21, 3'd1, 5'd4,  1'b0, 16'd4, 5'd21};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd4,  3'd1, 5'd4,  1'b0, 16'd4, 5'd4};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 5'd5,  3'd1, 5'd4,  1'b1, 16'd4, 5'd5};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 5'd5,  3'd1, 5'd4,  1'b1, 16'd4, 5'd5};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd5,  3'd1, 5'd4,  1'b1, 16'd4, 5'd4};

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d pc", i),          pc,          vecs[i].e_pc);
      checkOutput($sformatf("v%0d opcode", i),      opcode,      vecs[i].e_op);
      checkOutput($sformatf("v%0d ir_addr", i),     ir_addr,     vecs[i].e_ira);
      checkOutput($sformatf("v%0d halted", i),      halted,      vecs[i].e_hlt);
      checkOutput($sformatf("v%0d instr_count", i), instr_count, vecs[i].e_cnt);
      checkOutput($sformatf("v%0d addr", i),        addr,        vecs[i].e_addr);
    end

    // Still halted: ten cycles of every update strobe must leave state frozen.
    idleInputs();
    for (int i = 0; i < 10; i++) begin
      load_ir  = 1'b1;
      inc_pc   = 1'b1;
      load_pc  = (i % 2) == 0;
      mem_data = 8'($urandom);
      tick();
    end
    checkOutput("freeze pc",          pc,          32'd5);
    checkOutput("freeze opcode",      opcode,      32'd1);
    checkOutput("freeze ir_addr",     ir_addr,     32'd4);
    checkOutput("freeze instr_count", instr_count, 32'd4);
    checkOutput("freeze halted",      halted,      32'd1);

    idleInputs();
    rst_ = 1'b1;
    tick();
    rst_ = 1'b0;
    checkOutput("rst2 pc",          pc,          32'd0);
    checkOutput("rst2 opcode",      opcode,      32'd0);
    checkOutput("rst2 ir_addr",     ir_addr,     32'd0);
    checkOutput("rst2 halted",      halted,      32'd0);
    checkOutput("rst2 instr_count", instr_count, 32'd0);

    // Saturation of the 4-bit counter instance.
    for (int i = 1; i <= 20; i++) begin
      load_ir  = 1'b1;
      mem_data = 8'(i);
      tick();
      if (i == 15) checkOutput("sat at 15", instr_count_s, 32'd15);
    end
    load_ir = 1'b0;
    tick();
    checkOutput("sat held",       instr_count_s, 32'd15);
    checkOutput("wide count 20",  instr_count,   32'd20);
    checkOutput("sat ir_addr",    ir_addr_s,     32'd20);

`ifdef FETCH_BREAKPOINT_EN
    idleInputs();
    rst_ = 1'b1;
    tick();
    rst_     = 1'b0;
    bp_valid = 1'b1;
    bp_addr  = 5'd3;
    load_ir  = 1'b1;
    mem_data = 8'h11;
    tick();
    load_ir = 1'b0;
    checkOutput("bp no hit pc0", bp_hit, 32'd0);
    inc_pc = 1'b1;
    repeat (3) tick();
    inc_pc = 1'b0;
    checkOutput("bp pc3", pc, 32'd3);
    bp_valid = 1'b0;
    load_ir  = 1'b1;
    mem_data = 8'h47;
    tick();
    checkOutput("bp invalid no hit", bp_hit, 32'd0);
    checkOutput("bp invalid halted", halted, 32'd0);
    bp_valid = 1'b1;
    mem_data = 8'h6A;
    tick();
    load_ir = 1'b0;
    checkOutput("bp hit",         bp_hit,      32'd1);
    checkOutput("bp halted",      halted,      32'd1);
    checkOutput("bp opcode",      opcode,      32'd3);
    checkOutput("bp ir_addr",     ir_addr,     32'd10);
    checkOutput("bp instr_count", instr_count, 32'd3);
    tick();
    checkOutput("bp hit pulse", bp_hit, 32'd0);
    checkOutput("bp stays halted", halted, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
